// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: one operation per cycle through a valid/ready
// handshake, result, zero, overflow and illegal flags registered for writeback.
// Optional build macro ALU_SHIFT_OPS_EN adds SLL/SRL/SRA on opcodes 9-11;
// without it those opcodes are reported as illegal.
module alu_exec_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAGW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAGW-1:0]  out_tag,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_illegal
);

  localparam int unsigned Msb = WIDTH - 1;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] res;
  logic             ovf;
  logic             illegal;
  logic             accept;
  logic             lt_s;
  logic             lt_u;
`ifdef ALU_SHIFT_OPS_EN
  logic [4:0]       shamt;
  logic [WIDTH-1:0] sra_res;
`endif

  // Accept does not look at flush; flush only suppresses the register load.
  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  assign sum  = in_a + in_b;
  assign diff = in_a - in_b;
  assign lt_s = $signed(in_a) < $signed(in_b);
  assign lt_u = in_a < in_b;

`ifdef ALU_SHIFT_OPS_EN
  assign shamt   = in_b[4:0];
  assign sra_res = $unsigned($signed(in_a) >>> shamt);
`endif

  // Result, overflow and legality decode for the presented opcode.
  always_comb begin
    res     = '0;
    ovf     = 1'b0;
    illegal = 1'b0;
    case (in_op)
      4'd0: res = in_a & in_b;
      4'd1: res = in_a | in_b;
      4'd2: res = in_a ^ in_b;
      4'd3: res = ~(in_a | in_b);
      4'd4: begin
        res = sum;
        ovf = (in_a[Msb] == in_b[Msb]) && (sum[Msb] != in_a[Msb]);
      end
      4'd5: begin
        res = diff;
        ovf = (in_a[Msb] != in_b[Msb]) && (diff[Msb] != in_a[Msb]);
      end
      4'd6: res = {{(WIDTH-1){1'b0}}, lt_s};
      4'd7: res = {{(WIDTH-1){1'b0}}, lt_u};
      4'd8: res = in_b << 16;
`ifdef ALU_SHIFT_OPS_EN
      4'd9:  res = in_a << shamt;
      4'd10: res = in_a >> shamt;
      4'd11: res = sra_res;
`endif
      default: illegal = 1'b1;
    endcase
  end

  // Output register: flush beats accept, accept loads, drain clears valid only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_tag     <= '0;
      out_zero    <= 1'b0;
      out_ovf     <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_result  <= res;
      out_tag     <= in_tag;
      out_zero    <= (res == '0);
      out_ovf     <= ovf;
      out_illegal <= illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage.
module tb_alu_exec_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_zero;
  logic        out_ovf;
  logic        out_illegal;

  int total;
  int bad;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        il;
  } vec_t;

  alu_exec_stage #(.WIDTH(32), .TAGW(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .out_zero    (out_zero),
    .out_ovf     (out_ovf),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 4'd0; in_a = '0; in_b = '0; in_tag = '0;
    step();
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    total++; if (out_result !== 32'h0) begin bad++; $display("FAIL reset_result got %h want 0", out_result); end
    total++; if ({out_tag, out_zero, out_ovf, out_illegal} !== 8'h0) begin
      bad++; $display("FAIL reset_flags got %h want 00", {out_tag, out_zero, out_ovf, out_illegal});
    end
    out_ready = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_ops();
    vec_t vq[$];
    vq.push_back('{4'd1, 32'h0000_F0F0, 32'h0F0F_0000, 32'h0F0F_F0F0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'd0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'd2, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'd3, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0});
    vq.push_back('{4'd4, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0});
    vq.push_back('{4'd5, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0});
    vq.push_back('{4'd4, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0});
    vq.push_back('{4'd5, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
    vq.push_back('{4'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'd7, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0});
    vq.push_back('{4'd8, 32'hDEAD_BEEF, 32'h0000_1234, 32'h1234_0000, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'd13, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b1, 1'b0, 1'b1});
`ifdef ALU_SHIFT_OPS_EN
    vq.push_back('{4'd11, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'd9, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'd10, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0, 1'b0});
`else
    vq.push_back('{4'd11, 32'h8000_0000, 32'h0000_0024, 32'h0000_0000, 1'b1, 1'b0, 1'b1});
    vq.push_back('{4'd9, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1});
`endif
    out_ready = 1'b1;
    foreach (vq[i]) begin
      in_valid = 1'b1;
      in_op = vq[i].op; in_a = vq[i].a; in_b = vq[i].b; in_tag = 5'(i + 1);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ops_in_ready[%0d] got %b want 1", i, in_ready); end
      step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ops_valid[%0d] got %b want 1", i, out_valid); end
      total++; if (out_result !== vq[i].res) begin
        bad++; $display("FAIL ops_result[%0d] op=%0d got %h want %h", i, vq[i].op, out_result, vq[i].res);
      end
      total++; if ({out_zero, out_ovf, out_illegal} !== {vq[i].z, vq[i].o, vq[i].il}) begin
        bad++; $display("FAIL ops_flags[%0d] op=%0d got zoi=%b want %b", i, vq[i].op,
                        {out_zero, out_ovf, out_illegal}, {vq[i].z, vq[i].o, vq[i].il});
      end
      total++; if (out_tag !== 5'(i + 1)) begin
        bad++; $display("FAIL ops_tag[%0d] got %0d want %0d", i, out_tag, i + 1);
      end
    end
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ops_drain got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'd4; in_a = 32'd5; in_b = 32'd6; in_tag = 5'd1;
    step();
    total++; if (out_valid !== 1'b1 || out_result !== 32'd11 || out_tag !== 5'd1) begin
      bad++; $display("FAIL bp_first got v=%b r=%h t=%0d want v=1 r=0000000b t=1", out_valid, out_result, out_tag);
    end
    in_op = 4'd2; in_a = 32'h0000_00F0; in_b = 32'h0000_00FF; in_tag = 5'd2;
    for (int c = 0; c < 3; c++) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got %b want 0", c, in_ready); end
      step();
      total++; if (out_valid !== 1'b1 || out_result !== 32'd11 || out_tag !== 5'd1) begin
        bad++; $display("FAIL bp_hold[%0d] got v=%b r=%h t=%0d want v=1 r=0000000b t=1", c, out_valid, out_result, out_tag);
      end
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    step();
    total++; if (out_valid !== 1'b1 || out_result !== 32'h0000_000F || out_tag !== 5'd2) begin
      bad++; $display("FAIL bp_second got v=%b r=%h t=%0d want v=1 r=0000000f t=2", out_valid, out_result, out_tag);
    end
    in_op = 4'd5; in_a = 32'd10; in_b = 32'd3; in_tag = 5'd3;
    step();
    total++; if (out_valid !== 1'b1 || out_result !== 32'd7 || out_tag !== 5'd3) begin
      bad++; $display("FAIL bp_third got v=%b r=%h t=%0d want v=1 r=00000007 t=3", out_valid, out_result, out_tag);
    end
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'd0; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_tag = 5'd7;
    step();
    total++; if (out_valid !== 1'b1 || out_result !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL flush_setup got v=%b r=%h want v=1 r=ffffffff", out_valid, out_result);
    end
    out_ready = 1'b1; flush = 1'b1;
    in_op = 4'd4; in_a = 32'd1; in_b = 32'd2; in_tag = 5'd8;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got %b want 0", out_valid); end
    flush = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (out_valid !== 1'b0 || out_result === 32'd3) begin
        bad++; $display("FAIL flush_after[%0d] got v=%b r=%h want v=0 r!=3", c, out_valid, out_result);
      end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'd1; in_a = 32'h1; in_b = 32'h2; in_tag = 5'd9;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_result !== 32'h3) begin
      bad++; $display("FAIL arst_setup got v=%b r=%h want v=1 r=00000003", out_valid, out_result);
    end
    #1 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_result !== 32'h0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL arst_clear got v=%b r=%h rdy=%b want v=0 r=0 rdy=1", out_valid, out_result, in_ready);
    end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_after got %b want 0", out_valid); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_ops();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
